// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback with an illegal-instruction trap.
// All outputs are combinational from the current state and the live IR fields; reset forces them low.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWr,
    output logic       PCWr,
    output logic       RegWr,
    output logic       DmWr,
    output logic       illegal,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    state_t cur, nxt;

    logic rtype, is_add, is_jr, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, legal;

    always_comb begin
        rtype   = (opcode == 6'b000000);
        is_add  = rtype && ((funct == 6'b100000) || (funct == 6'b100001));
        is_jr   = rtype && (funct == 6'b001000);
        is_addi = (opcode == 6'b001000) || (opcode == 6'b001001);
        is_lw   = (opcode == 6'b100011);
        is_sw   = (opcode == 6'b101011);
        is_beq  = (opcode == 6'b000100);
        is_j    = (opcode == 6'b000010);
        is_jal  = (opcode == 6'b000011);
        legal   = is_add || is_jr || is_addi || is_lw || is_sw || is_beq || is_j || is_jal;
    end

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt      = cur;
        mem_req  = 1'b0;
        IorD     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RegWr    = 1'b0;
        DmWr     = 1'b0;
        illegal  = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = '0;
        ALUOp    = '0;
        PCSrc    = '0;
        RegDst   = '0;
        MemToReg = '0;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = 2'd1;
                    IRWr    = mem_ack;
                    PCWr    = mem_ack;
                    if (mem_ack) nxt = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'd3;
                    nxt     = legal ? EXEC : TRAP;
                end
                EXEC: begin
                    nxt = FETCH;
                    if (is_add) begin
                        ALUSrcA = 1'b1;
                        nxt     = WB;
                    end else if (is_addi || is_lw || is_sw) begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 2'd2;
                        nxt     = is_addi ? WB : MEM;
                    end else if (is_beq) begin
                        ALUSrcA = 1'b1;
                        ALUOp   = 3'd1;
                        PCSrc   = 2'd1;
                        PCWr    = zero;
                    end else if (is_j || is_jal) begin
                        PCSrc = 2'd2;
                        PCWr  = 1'b1;
                        if (is_jal) begin
                            RegWr    = 1'b1;
                            RegDst   = 2'd2;
                            MemToReg = 2'd2;
                        end
                    end else if (is_jr) begin
                        PCSrc = 2'd3;
                        PCWr  = 1'b1;
                    end else begin
                        // IR changed under us after decode: treat as illegal rather than guess
                        nxt = TRAP;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    DmWr    = is_sw;
                    if (mem_ack) nxt = is_sw ? FETCH : WB;
                end
                WB: begin
                    RegWr    = 1'b1;
                    RegDst   = is_add ? 2'd1 : 2'd0;
                    MemToReg = is_lw ? 2'd1 : 2'd0;
                    nxt      = FETCH;
                end
                TRAP: begin
                    illegal = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: each record is one clock of inputs plus the expected
// state/outputs; expectations go through a scoreboard queue and are compared on the falling edge.
module tb_multicycle_controller;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_JR = 6'b001000, FN_BAD = 6'b000000;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, iord, irwr, pcwr, regwr, dmwr, ill, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc, regdst, m2r;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic       z, ack;
        exp_t       e;
    } vec_t;

    typedef struct {
        int   idx;
        exp_t e;
    } sb_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ack = 1'b0;
    logic       mem_req, IorD, IRWr, PCWr, RegWr, DmWr, illegal, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, RegDst, MemToReg;
    logic [2:0] ALUOp, state;

    int n_checks = 0, n_pass = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr), .RegWr(RegWr), .DmWr(DmWr),
        .illegal(illegal), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .RegDst(RegDst), .MemToReg(MemToReg), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic mreq, iord, irwr, pcwr, regwr, dmwr,
                                input logic ill, srca, input logic [1:0] srcb, input logic [2:0] aluop,
                                input logic [1:0] pcsrc, regdst, m2r);
        exp_t e;
        e = '{st, mreq, iord, irwr, pcwr, regwr, dmwr, ill, srca, srcb, aluop, pcsrc, regdst, m2r};
        return e;
    endfunction

    function automatic exp_t x_fetch(input logic ack);
        return mk(3'd0, 1, 0, ack, ack, 0, 0, 0, 0, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0);
    endfunction
    function automatic exp_t x_dec();
        return mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'd0, 2'd0, 2'd0, 2'd0);
    endfunction
    function automatic exp_t x_trap();
        return mk(3'd7, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0);
    endfunction
    function automatic exp_t x_rst(input logic [2:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0);
    endfunction

    task automatic v(input logic rst, input logic [5:0] op, fn, input logic z, ack, input exp_t e);
        vec_t r;
        r = '{rst, op, fn, z, ack, e};
        tbl.push_back(r);
    endtask

    // Fetch + decode prologue shared by every instruction (zero-wait fetch).
    task automatic fd(input logic [5:0] op, fn, input logic z);
        v(0, op, fn, z, 1, x_fetch(1));
        v(0, op, fn, z, 1, x_dec());
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t  s;
            exp_t a;
            s = sb.pop_front();
            a = '{state, mem_req, IorD, IRWr, PCWr, RegWr, DmWr, illegal, ALUSrcA, ALUSrcB, ALUOp,
                  PCSrc, RegDst, MemToReg};
            n_checks++;
            if (a === s.e) n_pass++;
            else $display("FAIL vec%0d outputs: got %h, expected %h", s.idx, a, s.e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // lw, memory always ready: 0,1,2,3,4,0
        v(1, OP_LW, 6'd0, 0, 1, x_rst(3'd0));
        fd(OP_LW, 6'd0, 0);
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd1));

        // fetch held three cycles by mem_ack=0, then add
        for (int i = 0; i < 3; i++) v(0, OP_R, FN_ADD, 0, 0, x_fetch(0));
        fd(OP_R, FN_ADD, 0);
        v(0, OP_R, FN_ADD, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_R, FN_ADD, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd1, 2'd0));

        // addu writes rd as well
        fd(OP_R, FN_ADDU, 0);
        v(0, OP_R, FN_ADDU, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_R, FN_ADDU, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd1, 2'd0));

        // beq taken then not taken
        fd(OP_BEQ, 6'd0, 1);
        v(0, OP_BEQ, 6'd0, 1, 1, mk(3'd2, 0, 0, 0, 1, 0, 0, 0, 1, 2'd0, 3'd1, 2'd1, 2'd0, 2'd0));
        fd(OP_BEQ, 6'd0, 0);
        v(0, OP_BEQ, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd1, 2'd1, 2'd0, 2'd0));

        // jal, j, jr
        fd(OP_JAL, 6'd0, 0);
        v(0, OP_JAL, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd2, 2'd2));
        fd(OP_J, 6'd0, 0);
        v(0, OP_J, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd0, 2'd0));
        fd(OP_R, FN_JR, 0);
        v(0, OP_R, FN_JR, 0, 1, mk(3'd2, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd3, 2'd0, 2'd0));

        // addi / addiu
        fd(OP_ADDI, 6'd0, 0);
        v(0, OP_ADDI, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_ADDI, 6'd0, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        fd(OP_ADDIU, FN_ADD, 0);
        v(0, OP_ADDIU, FN_ADD, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_ADDIU, FN_ADD, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));

        // sw zero-wait: 4 cycles, MEM returns straight to FETCH
        fd(OP_SW, 6'd0, 0);
        v(0, OP_SW, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_SW, 6'd0, 0, 1, mk(3'd3, 1, 1, 0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));

        // sw stalled in MEM, reset lands on the second wait cycle
        fd(OP_SW, 6'd0, 0);
        v(0, OP_SW, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_SW, 6'd0, 0, 0, mk(3'd3, 1, 1, 0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(1, OP_SW, 6'd0, 0, 0, x_rst(3'd3));
        v(0, OP_SW, 6'd0, 0, 0, x_fetch(0));

        // lw with one MEM wait cycle
        fd(OP_LW, 6'd0, 0);
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_LW, 6'd0, 0, 0, mk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
        v(0, OP_LW, 6'd0, 0, 1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd1));

        // illegal opcode: trap held 10 cycles with inputs toggling, then reset recovers
        fd(OP_BAD, 6'd0, 0);
        for (int i = 0; i < 10; i++) v(0, OP_BAD, 6'd0, i[0], 1, x_trap());
        v(1, OP_BAD, 6'd0, 0, 1, x_rst(3'd7));
        v(0, OP_R, FN_BAD, 0, 1, x_fetch(1));

        // R-type with unknown funct also traps
        v(0, OP_R, FN_BAD, 0, 1, x_dec());
        for (int i = 0; i < 3; i++) v(0, OP_R, FN_BAD, 1, 1, x_trap());
        v(1, OP_R, FN_BAD, 0, 0, x_rst(3'd7));
        v(0, OP_R, FN_BAD, 0, 0, x_fetch(0));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            sb_t s;
            #1;
            reset   = tbl[i].rst;
            opcode  = tbl[i].op;
            funct   = tbl[i].fn;
            zero    = tbl[i].z;
            mem_ack = tbl[i].ack;
            s.idx   = i;
            s.e     = tbl[i].e;
            sb.push_back(s);
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
